// File: rtl/instr_dcd_pkg.sv
// instr_dcd_pkg: shared types and constants for the SPI register decoder.
// Instruction byte layout and decoder state encoding.
package instr_dcd_pkg;

  typedef enum logic {
    SETUP = 1'b0,
    DATA  = 1'b1
  } state_e;

  localparam int RW_BIT  = 7;
  localparam int INC_BIT = 6;
  localparam int FIELD_W = 6;

endpackage

// File: rtl/instr_dcd_burst_if.sv
// instr_dcd_burst_if: SPI byte side and register file side of the decoder.
// master = decoder, slave = SPI slave / register file environment.
interface instr_dcd_burst_if #(
  parameter int ADDR_W = 6
);

  logic              byte_sync;
  logic              frame_end;
  logic [7:0]        data_in;
  logic [7:0]        data_out;
  logic              read;
  logic              write;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        data_read;
  logic [7:0]        data_write;
  logic              active;
  logic              err;

  modport master (
    input  byte_sync,
    input  frame_end,
    input  data_in,
    input  data_read,
    output data_out,
    output read,
    output write,
    output addr,
    output data_write,
    output active,
    output err
  );

  modport slave (
    output byte_sync,
    output frame_end,
    output data_in,
    output data_read,
    input  data_out,
    input  read,
    input  write,
    input  addr,
    input  data_write,
    input  active,
    input  err
  );

endinterface

// File: rtl/instr_dcd_burst_addr_ctr.sv
// burst_addr_ctr: register address with wrap-around increment and
// data byte counter; done flags the last byte a burst may take.
module burst_addr_ctr #(
  parameter int ADDR_W    = 6,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic              step,
  input  logic              count,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] next_addr,
  output logic              done
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] LAST = CW'(MAX_BURST - 1);

  logic [CW-1:0] cnt;

  assign next_addr = addr + ADDR_W'(1);
  assign done      = (cnt == LAST);

  // Load on an instruction, then step address / count data bytes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr <= '0;
      cnt  <= '0;
    end else if (load) begin
      addr <= load_addr;
      cnt  <= '0;
    end else begin
      if (step)
        addr <= next_addr;
      if (count)
        cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/instr_dcd_burst.sv
// instr_dcd_burst: SPI instruction/data decoder with auto-increment bursts.
// Optional range check compiled in by INSTR_DCD_RANGE_CHECK_EN.
module instr_dcd_burst
  import instr_dcd_pkg::*;
#(
  parameter int ADDR_W    = 6,
  parameter int NUM_REGS  = 64,
  parameter int MAX_BURST = 16
) (
  input logic                clk,
  input logic                rst_n,
  instr_dcd_burst_if.master  bus
);

  state_e            state;
  logic              rw;
  logic              inc;
  logic              pend_inc;
  logic              fld_bad;
  logic              rd;
  logic              wr;
  logic [7:0]        dout;
  logic [7:0]        dwr;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] next_addr;
  logic [ADDR_W-1:0] ins_addr;
  logic              done;
  logic              last;
  logic              take_ins;
  logic              take_dat;
  logic              step;
  logic              ins_hi;
  logic              ins_bad;
  logic              cur_bad;
  logic              nxt_bad;

  assign ins_addr = bus.data_in[ADDR_W-1:0];
  assign take_ins = bus.byte_sync & ~bus.frame_end
                  & (state == SETUP);
  assign take_dat = bus.byte_sync & ~bus.frame_end
                  & (state == DATA);
  assign last     = ~inc | done;
  assign step     = (take_dat & ~rw & ~last)
                  | (pend_inc & ~bus.frame_end);

`ifdef INSTR_DCD_RANGE_CHECK_EN
  logic err_q;

  function automatic logic oor(input logic [ADDR_W-1:0] a);
    return 32'(a) >= 32'(NUM_REGS);
  endfunction

  assign ins_hi  = (bus.data_in[FIELD_W-1:0] >> ADDR_W) != '0;
  assign ins_bad = ins_hi | oor(ins_addr);
  assign cur_bad = fld_bad | oor(addr);
  assign nxt_bad = fld_bad | oor(next_addr);

  // Sticky error: cleared by each instruction, set by any rejected access.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (take_ins)
      err_q <= ~bus.data_in[RW_BIT] & ins_bad;
    else if (take_dat & rw & cur_bad)
      err_q <= 1'b1;
    else if (take_dat & ~rw & ~last & nxt_bad)
      err_q <= 1'b1;
  end

  assign bus.err = err_q;
`else
  assign ins_hi  = 1'b0;
  assign ins_bad = 1'b0;
  assign cur_bad = fld_bad;
  assign nxt_bad = fld_bad;
  assign bus.err = 1'b0;
`endif

  burst_addr_ctr #(
    .ADDR_W    (ADDR_W),
    .MAX_BURST (MAX_BURST)
  ) u_ctr (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (take_ins),
    .load_addr (ins_addr),
    .step      (step),
    .count     (take_dat),
    .addr      (addr),
    .next_addr (next_addr),
    .done      (done)
  );

  // Decode instruction/data bytes into strobes; frame_end wins.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= SETUP;
      rw       <= 1'b0;
      inc      <= 1'b0;
      pend_inc <= 1'b0;
      fld_bad  <= 1'b0;
      rd       <= 1'b0;
      wr       <= 1'b0;
      dout     <= 8'h00;
      dwr      <= 8'h00;
    end else begin
      rd       <= 1'b0;
      wr       <= 1'b0;
      pend_inc <= 1'b0;
      if (rd)
        dout <= bus.data_read;
      if (bus.frame_end) begin
        state <= SETUP;
      end else begin
        unique case (1'b1)
          take_ins: begin
            rw      <= bus.data_in[RW_BIT];
            inc     <= bus.data_in[INC_BIT];
            fld_bad <= ins_hi;
            state   <= DATA;
            if (bus.data_in[RW_BIT])
              dout <= 8'h00;
            else if (ins_bad)
              dout <= 8'h00;
            else
              rd <= 1'b1;
          end
          take_dat: begin
            if (rw) begin
              dwr      <= bus.data_in;
              wr       <= ~cur_bad;
              pend_inc <= ~last;
            end else if (!last) begin
              if (nxt_bad)
                dout <= 8'h00;
              else
                rd <= 1'b1;
            end
            if (last)
              state <= SETUP;
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.data_out   = dout;
  assign bus.read       = rd;
  assign bus.write      = wr;
  assign bus.addr       = addr;
  assign bus.data_write = dwr;
  assign bus.active     = (state == DATA);

endmodule

// File: tb/tb_instr_dcd_burst.sv
// tb_instr_dcd_burst: directed table, timing sequences and random
// byte streams checked against a transaction-level model.
module tb_instr_dcd_burst;

  localparam int AW = 6;
  localparam int MB = 16;
`ifdef INSTR_DCD_RANGE_CHECK_EN
  localparam int NR = 8;
  localparam bit RC = 1'b1;
`else
  localparam int NR = 64;
  localparam bit RC = 1'b0;
`endif
  localparam int NA = 1 << AW;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  instr_dcd_burst_if #(.ADDR_W(AW)) bus ();

  instr_dcd_burst #(
    .ADDR_W    (AW),
    .NUM_REGS  (NR),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic          w;
    logic [AW-1:0] a;
    logic [7:0]    d;
  } ev_t;

  typedef struct {
    bit         fe;
    logic [7:0] b;
    bit         act;
    logic [7:0] dout;
    bit         err;
    bit         ev;
    ev_t        e;
  } vec_t;

  logic [7:0] regs [NA];
  logic [7:0] mregs [NA];
  ev_t act_q[$];
  ev_t exp_q[$];
  vec_t tbl[$];
  int n_vec = 0;
  int n_fail = 0;

  bit m_act, m_err, m_rw, m_inc, m_fbad;
  logic [7:0] m_dout;
  int m_a, m_n;

  assign bus.data_read = regs[bus.addr];

  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.write) begin
        regs[bus.addr] = bus.data_write;
        act_q.push_back({1'b1, bus.addr, bus.data_write});
      end
      if (bus.read)
        act_q.push_back({1'b0, bus.addr, 8'h00});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_events(input string nm);
    chk({nm, "_nev"}, 32'(act_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < act_q.size() && i < exp_q.size(); i++)
      chk({nm, "_ev"}, 32'(act_q[i]), 32'(exp_q[i]));
    act_q.delete();
    exp_q.delete();
  endtask

  function automatic bit m_oor(input int a);
    return RC && (m_fbad || a >= NR);
  endfunction

  task automatic m_read(input int a);
    if (m_oor(a)) begin
      m_dout = 8'h00;
      m_err  = 1'b1;
    end else begin
      exp_q.push_back({1'b0, AW'(a), 8'h00});
      m_dout = mregs[a];
    end
  endtask

  task automatic m_step(input bit fe, input bit bs, input logic [7:0] b);
    if (fe) begin
      m_act = 1'b0;
    end else if (bs && !m_act) begin
      m_rw   = b[7];
      m_inc  = b[6];
      m_a    = int'(b[5:0]) % NA;
      m_fbad = (int'(b[5:0]) >> AW) != 0;
      m_n    = 0;
      m_err  = 1'b0;
      m_act  = 1'b1;
      if (m_rw) m_dout = 8'h00;
      else m_read(m_a);
    end else if (bs) begin
      m_n++;
      if (m_rw) begin
        if (m_oor(m_a)) m_err = 1'b1;
        else begin
          exp_q.push_back({1'b1, AW'(m_a), b});
          mregs[m_a] = b;
        end
      end
      if (!m_inc || m_n == MB) m_act = 1'b0;
      else begin
        m_a = (m_a + 1) % NA;
        if (!m_rw) m_read(m_a);
      end
    end
  endtask

  task automatic apply(input bit fe, input bit bs, input logic [7:0] b);
    @(negedge clk);
    bus.frame_end = fe;
    bus.byte_sync = bs;
    bus.data_in   = b;
    @(negedge clk);
    bus.frame_end = 1'b0;
    bus.byte_sync = 1'b0;
    repeat (9) @(negedge clk);
  endtask

  function automatic void add(input bit fe, input logic [7:0] b,
                              input bit act, input logic [7:0] dout,
                              input bit err, input bit ev, input ev_t e);
    tbl.push_back('{fe, b, act, dout, err, ev, e});
  endfunction

  task automatic chk_idle(input string nm);
    chk({nm, "_active"}, 32'(bus.active), 32'(0));
    chk({nm, "_read"}, 32'(bus.read), 32'(0));
    chk({nm, "_write"}, 32'(bus.write), 32'(0));
    chk({nm, "_addr"}, 32'(bus.addr), 32'(0));
    chk({nm, "_dout"}, 32'(bus.data_out), 32'(0));
    chk({nm, "_dwr"}, 32'(bus.data_write), 32'(0));
    chk({nm, "_err"}, 32'(bus.err), 32'(0));
  endtask

  initial begin
    int wexp;
    int r;
    bit fe;
    bit bs;
    logic [7:0] b;

    bus.byte_sync = 1'b0;
    bus.frame_end = 1'b0;
    bus.data_in   = 8'h00;
    for (int i = 0; i < NA; i++) regs[i] = 8'(3 * i + 1);
    regs[10] = 8'h77;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst_n = 1'b1;

`ifdef INSTR_DCD_RANGE_CHECK_EN
    add(1'b0, 8'h89, 1'b1, 8'h00, 1'b0, 1'b0, '0);
    add(1'b0, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, '0);
    add(1'b0, 8'h03, 1'b1, 8'h0A, 1'b0, 1'b1, {1'b0, 6'h03, 8'h00});
    add(1'b0, 8'h00, 1'b0, 8'h0A, 1'b0, 1'b0, '0);
    add(1'b0, 8'h4E, 1'b1, 8'h00, 1'b1, 1'b0, '0);
    add(1'b0, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, '0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, '0);
    add(1'b0, 8'h7F, 1'b1, 8'h00, 1'b1, 1'b0, '0);
    add(1'b0, 8'h00, 1'b1, 8'h01, 1'b1, 1'b1, {1'b0, 6'h00, 8'h00});
    add(1'b1, 8'h00, 1'b0, 8'h01, 1'b1, 1'b0, '0);
    add(1'b0, 8'h05, 1'b1, 8'h10, 1'b0, 1'b1, {1'b0, 6'h05, 8'h00});
    add(1'b1, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0, '0);
`else
    add(1'b0, 8'h85, 1'b1, 8'h00, 1'b0, 1'b0, '0);
    add(1'b0, 8'h3C, 1'b0, 8'h00, 1'b0, 1'b1, {1'b1, 6'h05, 8'h3C});
    add(1'b0, 8'h0A, 1'b1, 8'h77, 1'b0, 1'b1, {1'b0, 6'h0A, 8'h00});
    add(1'b0, 8'h00, 1'b0, 8'h77, 1'b0, 1'b0, '0);
    add(1'b0, 8'hC2, 1'b1, 8'h00, 1'b0, 1'b0, '0);
    add(1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 1'b1, {1'b1, 6'h02, 8'h11});
    add(1'b0, 8'h22, 1'b1, 8'h00, 1'b0, 1'b1, {1'b1, 6'h03, 8'h22});
    add(1'b0, 8'h33, 1'b1, 8'h00, 1'b0, 1'b1, {1'b1, 6'h04, 8'h33});
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    add(1'b0, 8'h81, 1'b1, 8'h00, 1'b0, 1'b0, '0);
    add(1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, '0);
    add(1'b0, 8'h04, 1'b1, 8'h33, 1'b0, 1'b1, {1'b0, 6'h04, 8'h00});
    add(1'b1, 8'h00, 1'b0, 8'h33, 1'b0, 1'b0, '0);
    add(1'b0, 8'h7F, 1'b1, 8'hBE, 1'b0, 1'b1, {1'b0, 6'h3F, 8'h00});
    add(1'b0, 8'h00, 1'b1, 8'h01, 1'b0, 1'b1, {1'b0, 6'h00, 8'h00});
    add(1'b0, 8'h00, 1'b1, 8'h04, 1'b0, 1'b1, {1'b0, 6'h01, 8'h00});
    add(1'b1, 8'h00, 1'b0, 8'h04, 1'b0, 1'b0, '0);
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      apply(tbl[i].fe, !tbl[i].fe, tbl[i].b);
      chk($sformatf("t%0d_active", i), 32'(bus.active), 32'(tbl[i].act));
      chk($sformatf("t%0d_dout", i), 32'(bus.data_out), 32'(tbl[i].dout));
      chk($sformatf("t%0d_err", i), 32'(bus.err), 32'(tbl[i].err));
      chk($sformatf("t%0d_nev", i), 32'(act_q.size()), 32'(tbl[i].ev));
      if (tbl[i].ev && act_q.size() > 0)
        chk($sformatf("t%0d_ev", i), 32'(act_q[0]), 32'(tbl[i].e));
      act_q.delete();
    end

    // Read latency: strobe in N+1, data_out in N+2.
    regs[2] = 8'h77;
    @(negedge clk);
    bus.byte_sync = 1'b1;
    bus.data_in   = 8'h02;
    @(negedge clk);
    bus.byte_sync = 1'b0;
    chk("rd_n1_read", 32'(bus.read), 32'(1));
    chk("rd_n1_addr", 32'(bus.addr), 32'(2));
    chk("rd_n1_write", 32'(bus.write), 32'(0));
    @(negedge clk);
    chk("rd_n2_read", 32'(bus.read), 32'(0));
    chk("rd_n2_dout", 32'(bus.data_out), 32'(8'h77));
    repeat (8) @(negedge clk);
    apply(1'b0, 1'b1, 8'h00);
    chk("rd_end_active", 32'(bus.active), 32'(0));
    act_q.delete();

    // Burst write: strobe at M+1 with old addr, addr+1 at M+2.
    apply(1'b0, 1'b1, 8'hC5);
    @(negedge clk);
    bus.byte_sync = 1'b1;
    bus.data_in   = 8'h99;
    @(negedge clk);
    bus.byte_sync = 1'b0;
    chk("wr_m1_write", 32'(bus.write), 32'(1));
    chk("wr_m1_read", 32'(bus.read), 32'(0));
    chk("wr_m1_addr", 32'(bus.addr), 32'(5));
    chk("wr_m1_data", 32'(bus.data_write), 32'(8'h99));
    @(negedge clk);
    chk("wr_m2_write", 32'(bus.write), 32'(0));
    chk("wr_m2_addr", 32'(bus.addr), 32'(6));
    repeat (8) @(negedge clk);
    apply(1'b1, 1'b0, 8'h00);
    chk("wr_regfile", 32'(regs[5]), 32'(8'h99));
    act_q.delete();

    // Burst length limit.
    apply(1'b0, 1'b1, 8'hC0);
    wexp = 0;
    for (int i = 0; i < MB; i++) begin
      apply(1'b0, 1'b1, 8'(i + 8'h40));
      chk($sformatf("mb%0d_active", i), 32'(bus.active),
          32'(i < MB - 1));
      if (!RC || i < NR) wexp++;
    end
    chk("mb_writes", 32'(act_q.size()), 32'(wexp));
    act_q.delete();

    // Reset mid-frame with a byte arriving on the same edge.
    apply(1'b0, 1'b1, 8'hC3);
    act_q.delete();
    @(negedge clk);
    rst_n = 1'b0;
    bus.byte_sync = 1'b1;
    bus.data_in   = 8'h44;
    @(negedge clk);
    bus.byte_sync = 1'b0;
    chk_idle("rst_mid");
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("rst_mid_nostrobe", 32'(act_q.size()), 32'(0));
    act_q.delete();

    // Random streams against the model.
    for (int i = 0; i < NA; i++) begin
      regs[i]  = 8'($urandom);
      mregs[i] = regs[i];
    end
    m_act  = 1'b0;
    m_err  = 1'b0;
    m_fbad = 1'b0;
    m_dout = 8'h00;
    for (int k = 0; k < 400; k++) begin
      r  = int'($urandom_range(0, 99));
      fe = (r < 8);
      bs = !fe || (r < 3);
      b  = 8'($urandom);
      apply(fe, bs, b);
      m_step(fe, bs, b);
      chk($sformatf("rnd%0d_active", k), 32'(bus.active), 32'(m_act));
      chk($sformatf("rnd%0d_dout", k), 32'(bus.data_out), 32'(m_dout));
      chk($sformatf("rnd%0d_err", k), 32'(bus.err), 32'(m_err));
      chk_events($sformatf("rnd%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
